// File: rtl/rnn_forward_acc_requant.sv
// rnn_forward_acc_requant
//   Takes signed products from the multiplier stage and sums N_TERMS of them,
//   plus a bias, into one hidden-unit pre-activation. The sum is then
//   rounded (half-up), shifted right by FRAC_SHIFT and saturated to OUT_WIDTH.
//   The result is sent out on a valid/ready output. Partial sums stay inside.
// Ports
//   ap_clk, ap_rst_n        clock, async active-low reset
//   prod_tdata/tvalid/tready  product input stream (a beat is tvalid & tready)
//   bias                    bias, sampled on the first beat of each dot product
//   out_tdata/tvalid/tready result output stream
//   out_sat                 result was clipped (qualified by out_tvalid)
//   busy                    at least one product of the current dot product taken
module rnn_forward_acc_requant #(
  parameter int PROD_WIDTH = 71,
  parameter int ACC_WIDTH  = 80,
  parameter int BIAS_WIDTH = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 24,
  parameter int N_TERMS    = 64
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [PROD_WIDTH-1:0] prod_tdata,
  input  logic                         prod_tvalid,
  output logic                         prod_tready,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  output logic signed [OUT_WIDTH-1:0]  out_tdata,
  output logic                         out_tvalid,
  input  logic                         out_tready,
  output logic                         out_sat,
  output logic                         busy
);

  localparam int CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {ST_ACC, ST_OUT} state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0]  out_tdata_q, out_tdata_d;
  logic                         out_tvalid_q, out_tvalid_d;
  logic                         out_sat_q, out_sat_d;
  logic                         busy_q, busy_d;

  logic                         beat;
  logic signed [ACC_WIDTH-1:0]  prod_ext, bias_ext, sum_nxt, rnd_sum, req_r;
  logic signed [OUT_WIDTH-1:0]  req_data;
  logic                         req_sat;

  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
  assign bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};

  assign prod_tready = (state_q == ST_ACC);
  assign beat        = prod_tvalid & prod_tready;

  // The first beat starts from the bias, not from the stale accumulator.
  assign sum_nxt = ((cnt_q == '0) ? bias_ext : acc_q) + prod_ext;

  // Round half-up, then do an arithmetic shift. ACC_WIDTH has enough headroom,
  // so adding half an LSB cannot overflow.
  assign rnd_sum = sum_nxt + RND_HALF;
  assign req_r   = rnd_sum >>> FRAC_SHIFT;

  always_comb begin
    req_sat  = 1'b0;
    req_data = req_r[OUT_WIDTH-1:0];
    if (req_r > OUT_MAX) begin
      req_sat  = 1'b1;
      req_data = OUT_MAX[OUT_WIDTH-1:0];
    end else if (req_r < OUT_MIN) begin
      req_sat  = 1'b1;
      req_data = OUT_MIN[OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    out_tdata_d  = out_tdata_q;
    out_tvalid_d = out_tvalid_q;
    out_sat_d    = out_sat_q;
    busy_d       = busy_q;
    case (state_q)
      ST_ACC: begin
        if (beat) begin
          acc_d = sum_nxt;
          if (cnt_q == '0) busy_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            out_tdata_d  = req_data;
            out_sat_d    = req_sat;
            out_tvalid_d = 1'b1;
            cnt_d        = '0;
            busy_d       = 1'b0;
            state_d      = ST_OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (out_tready) begin
          out_tvalid_d = 1'b0;
          state_d      = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= ST_ACC;
      cnt_q        <= '0;
      acc_q        <= '0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      out_sat_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      out_tdata_q  <= out_tdata_d;
      out_tvalid_q <= out_tvalid_d;
      out_sat_q    <= out_sat_d;
      busy_q       <= busy_d;
    end
  end

  assign out_tdata  = out_tdata_q;
  assign out_tvalid = out_tvalid_q;
  assign out_sat    = out_sat_q;
  assign busy       = busy_q;

  a_out_stable: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    out_tvalid && !out_tready |=> $stable(out_tdata) && $stable(out_sat));
  a_no_overlap: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    !(prod_tready && out_tvalid));

endmodule

// File: tb/tb_rnn_forward_acc_requant.sv
// Testbench for rnn_forward_acc_requant, built with N_TERMS=4.
// It runs the directed cases first, then randomized dot products with gaps
// and backpressure. Expected results come from a reference model that keeps
// a list of the products taken.
module tb_rnn_forward_acc_requant;
  localparam int PW = 71, AW = 80, BW = 32, OW = 16, FS = 24, NT = 4;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n = 1'b1;
  logic signed [PW-1:0] prod_tdata = '0;
  logic                 prod_tvalid = 1'b0;
  logic                 prod_tready;
  logic signed [BW-1:0] bias = '0;
  logic signed [OW-1:0] out_tdata;
  logic                 out_tvalid;
  logic                 out_tready = 1'b0;
  logic                 out_sat;
  logic                 busy;

  rnn_forward_acc_requant #(
    .PROD_WIDTH(PW), .ACC_WIDTH(AW), .BIAS_WIDTH(BW),
    .OUT_WIDTH(OW), .FRAC_SHIFT(FS), .N_TERMS(NT)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(prod_tready),
    .bias(bias),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0, n_err = 0;
  logic signed [127:0] q_terms[$];
  logic signed [127:0] m_bias;
  logic [16:0]         exp_q[$];

  task automatic chk(input string tag, input logic signed [79:0] got,
                     input logic signed [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference requantization: floor((s + 2^23) / 2^24), then clamp.
  function automatic logic [16:0] requant(input logic signed [127:0] s);
    logic signed [127:0] t, r;
    t = s + 128'sd8388608;
    if (t >= 0) r = t / 128'sd16777216;
    else        r = -((-t + 128'sd16777215) / 128'sd16777216);
    if (r > 128'sd32767)  return {1'b1, 16'h7fff};
    if (r < -128'sd32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  task automatic beat(input logic signed [127:0] v, input logic signed [31:0] b);
    int g = 0;
    logic signed [127:0] s;
    @(negedge ap_clk);
    prod_tvalid = 1'b1; prod_tdata = v[PW-1:0]; bias = b;
    while (!prod_tready && g < 50) begin @(negedge ap_clk); g++; end
    if (!prod_tready) begin
      chk("beat_timeout", {79'd0, prod_tready}, 80'sd1);
      prod_tvalid = 1'b0;
      return;
    end
    if (q_terms.size() == 0) m_bias = 128'(b);
    q_terms.push_back(v);
    if (q_terms.size() == NT) begin
      s = m_bias;
      foreach (q_terms[i]) s += q_terms[i];
      exp_q.push_back(requant(s));
      q_terms.delete();
    end
    @(posedge ap_clk); #1;
    prod_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
  endtask

  task automatic dot(input logic signed [31:0] b, input logic signed [127:0] a0,
                     input logic signed [127:0] a1, input logic signed [127:0] a2,
                     input logic signed [127:0] a3);
    beat(a0, b); beat(a1, b); beat(a2, b); beat(a3, b);
  endtask

  task automatic get_result(input string tag, input int hold);
    logic [16:0] e;
    int g = 0;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'd0;
    @(negedge ap_clk);
    while (!out_tvalid && g < 50) begin @(negedge ap_clk); g++; end
    chk({tag, "_vld"},  {79'd0, out_tvalid}, 80'sd1);
    chk({tag, "_data"}, out_tdata, $signed(e[15:0]));
    chk({tag, "_sat"},  {79'd0, out_sat}, {79'd0, e[16]});
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      chk({tag, "_hold_data"}, out_tdata, $signed(e[15:0]));
      chk({tag, "_hold_sat"},  {79'd0, out_sat}, {79'd0, e[16]});
      chk({tag, "_hold_vld"},  {79'd0, out_tvalid}, 80'sd1);
      chk({tag, "_hold_prdy"}, {79'd0, prod_tready}, 80'sd0);
    end
    out_tready = 1'b1;
    @(posedge ap_clk); #1;
    out_tready = 1'b0;
    chk({tag, "_vld_drop"}, {79'd0, out_tvalid}, 80'sd0);
    chk({tag, "_prdy_back"}, {79'd0, prod_tready}, 80'sd1);
  endtask

  localparam logic signed [127:0] ONE = 128'sd16777216;  // 1.0 in Q.24

  initial begin
    logic signed [127:0] v;
    logic signed [31:0]  b;
    int m;

    // Reset values, checked with no clock edge in between.
    #2 ap_rst_n = 1'b0;
    #1;
    chk("rst_vld",  {79'd0, out_tvalid}, 80'sd0);
    chk("rst_data", out_tdata, 80'sd0);
    chk("rst_sat",  {79'd0, out_sat}, 80'sd0);
    chk("rst_busy", {79'd0, busy}, 80'sd0);
    chk("rst_prdy", {79'd0, prod_tready}, 80'sd1);
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;

    // Basic: latency and the busy window.
    chk("basic_busy0", {79'd0, busy}, 80'sd0);
    beat(ONE, 32'sd0);
    chk("basic_busy1", {79'd0, busy}, 80'sd1);
    beat(ONE, 32'sd0); beat(ONE, 32'sd0);
    chk("basic_busy3", {79'd0, busy}, 80'sd1);
    chk("basic_novld", {79'd0, out_tvalid}, 80'sd0);
    beat(ONE, 32'sd0);
    chk("basic_lat_vld", {79'd0, out_tvalid}, 80'sd1);
    chk("basic_busy4", {79'd0, busy}, 80'sd0);
    chk("basic_val4", out_tdata, 80'sd4);
    get_result("basic", 0);

    // Bias and rounding.
    dot(32'sd8388608, 0, 0, 0, 0);   get_result("rnd_half_up", 0);
    chk("rnd_half_up_val", out_tdata, 80'sd1);
    dot(-32'sd8388608, 0, 0, 0, 0);  get_result("rnd_neg_half", 0);
    dot(-32'sd8388609, 0, 0, 0, 0);  get_result("rnd_neg_one", 0);
    chk("rnd_neg_one_val", out_tdata, -80'sd1);

    // Saturation boundaries.
    v = 128'sd1 <<< 40;
    dot(32'sd0, v, v, v, v);         get_result("sat_pos", 0);
    dot(32'sd0, -v, -v, -v, -v);     get_result("sat_neg", 0);
    dot(32'sd0, 128'sd32767 * ONE, 0, 0, 0);  get_result("max_exact", 0);
    dot(32'sd8388608, 128'sd32767 * ONE, 0, 0, 0);  get_result("max_round_sat", 0);
    dot(-32'sd8388609, -128'sd32768 * ONE, 0, 0, 0); get_result("min_round_sat", 0);

    // Backpressure, followed by a negative dot product.
    dot(32'sd0, ONE, ONE, ONE, ONE); get_result("bp_hold", 5);
    dot(32'sd0, -ONE, -ONE, -ONE, -ONE); get_result("bp_neg4", 0);

    // Gaps on prod_tvalid; bias changes after the first beat.
    beat(ONE, 32'sd0); idle(2);
    beat(ONE, 32'sd1 <<< 30); idle(1);
    beat(ONE, 32'sd1 <<< 30);
    beat(ONE, 32'sd1 <<< 30);
    get_result("gaps", 0);

    // Reset in the middle of an accumulation.
    beat(5 * ONE, 32'sd0); beat(5 * ONE, 32'sd0);
    chk("rst_mid_busy_pre", {79'd0, busy}, 80'sd1);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {79'd0, busy}, 80'sd0);
    chk("rst_mid_vld",  {79'd0, out_tvalid}, 80'sd0);
    q_terms.delete();
    @(negedge ap_clk) ap_rst_n = 1'b1;

    // Reset while a result is pending.
    dot(32'sd0, 7 * ONE, 0, 0, 0);
    chk("rst_out_pre_vld", {79'd0, out_tvalid}, 80'sd1);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("rst_out_vld",  {79'd0, out_tvalid}, 80'sd0);
    chk("rst_out_data", out_tdata, 80'sd0);
    chk("rst_out_prdy", {79'd0, prod_tready}, 80'sd1);
    exp_q.delete();
    q_terms.delete();
    @(negedge ap_clk) ap_rst_n = 1'b1;
    dot(32'sd0, 3 * ONE, 3 * ONE, 3 * ONE, 3 * ONE);
    get_result("post_rst", 0);
    chk("post_rst_val", out_tdata, 80'sd12);

    // Random dot products with gaps, backpressure and random bias.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NT; k++) begin
        m = int'($urandom_range(0, 65535)) - 32768;
        v = 128'(m) <<< $urandom_range(8, 40);
        b = $signed($urandom()) >>> $urandom_range(0, 10);
        idle($urandom_range(0, 2));
        beat(v, b);
      end
      get_result("rand", $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
